// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue path: operand/opcode widths, the ALU
// opcode encodings, the issue-entry layout and the issue-queue FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int OPCODE_W  = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_ORA = 3'b111
  } alu_op_e;

  // One queued instruction; the packed order matches {opcode, x, y}.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [ALU_WIDTH-1:0] x;
    logic [ALU_WIDTH-1:0] y;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_fifo.sv
// -----------------------------------------------------------------------------
// alu_issue_fifo
// Entry storage plus read/write pointers and occupancy for the issue queue.
// The parent guarantees push only when not full and pop only when not empty.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, pop, flush  write head entry / retire oldest entry / empty the queue
//   wr_data           entry written on push
//   rd_data           oldest entry (valid when count != 0)
//   count             current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu_issue_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 35
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [ENTRY_W-1:0]     wr_data,
  output logic [ENTRY_W-1:0]     rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are never visible because count
  // gates every read in the parent.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Unregistered head read: the parent's X/Y/Opcode flops act as the read
  // register, which keeps issue latency at one edge after the push edge.
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
// Buffers ALU instructions and issues them one per cycle, in order, with a
// registered operand/opcode interface and a one-cycle Enable strobe.
// Optional feature: define ALU_ISSUE_STATS_EN to add the ISSUE_CNT output,
// a 16-bit wrapping count of Enable pulses (cleared only by reset).
// Ports:
//   CLK, RST                  clock, asynchronous active-low reset
//   IN_VALID/IN_READY         producer handshake (IN_READY = not full)
//   IN_OPCODE, IN_X, IN_Y     offered instruction
//   HOLD                      downstream stall, blocks issue while high
//   FLUSH                     synchronous discard of all queued entries
//   Enable, X, Y, Opcode      registered issue interface to the ALU
//   COUNT                     current occupancy
//   ISSUE_CNT                 issue counter (ALU_ISSUE_STATS_EN only)
// -----------------------------------------------------------------------------
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [OPCODE_W-1:0]    IN_OPCODE,
  input  logic [WIDTH-1:0]       IN_X,
  input  logic [WIDTH-1:0]       IN_Y,
  input  logic                   HOLD,
  input  logic                   FLUSH,
  output logic                   Enable,
  output logic [WIDTH-1:0]       X,
  output logic [WIDTH-1:0]       Y,
  output logic [OPCODE_W-1:0]    Opcode,
  output logic [$clog2(DEPTH):0] COUNT
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]            ISSUE_CNT
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = OPCODE_W + 2 * WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  issue_state_e         state_q, state_d;
  logic                 enable_q, enable_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [OPCODE_W-1:0]  opcode_q, opcode_d;

  logic                 push;
  logic                 pop;
  logic [CNT_W-1:0]     count;
  logic [ENTRY_W-1:0]   head;
  logic [OPCODE_W-1:0]  head_op;
  logic [WIDTH-1:0]     head_x;
  logic [WIDTH-1:0]     head_y;

  alu_issue_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .push    (push),
    .pop     (pop),
    .flush   (FLUSH),
    .wr_data ({IN_OPCODE, IN_X, IN_Y}),
    .rd_data (head),
    .count   (count)
  );

  assign {head_op, head_x, head_y} = head;

  // Full refuses the offer even when a pop frees a slot at the same edge.
  assign IN_READY = (count != FULL_CNT);

  // Non-IDLE always implies a non-empty queue, so the state alone gates pop.
  // FLUSH overrides both directions; the offered entry is simply dropped.
  always_comb begin
    push = IN_VALID && IN_READY && !FLUSH;
    pop  = (state_q != ST_IDLE) && !HOLD && !FLUSH;
  end

  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (push) state_d = ST_RUN;
        ST_RUN, ST_STALL: begin
          if (HOLD)                              state_d = ST_STALL;
          else if (count == CNT_W'(1) && !push)  state_d = ST_IDLE;
          else                                   state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Issue registers load only on a pop and otherwise keep the last issue.
  always_comb begin
    enable_d = pop;
    x_d      = x_q;
    y_d      = y_q;
    opcode_d = opcode_q;
    if (pop) begin
      x_d      = head_x;
      y_d      = head_y;
      opcode_d = head_op;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      opcode_q <= OP_NOP;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      x_q      <= x_d;
      y_q      <= y_d;
      opcode_q <= opcode_d;
    end
  end

  assign Enable = enable_q;
  assign X      = x_q;
  assign Y      = y_q;
  assign Opcode = opcode_q;
  assign COUNT  = count;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  // Counts at the pop edge so ISSUE_CNT already includes the visible pulse.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (pop) issue_cnt_d = issue_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) issue_cnt_q <= '0;
    else      issue_cnt_q <= issue_cnt_d;
  end

  assign ISSUE_CNT = issue_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_queue
// Directed bench for alu_issue_queue with a queue-based reference model.
// Inputs change on the falling edge; the model advances on the rising edge;
// outputs are compared against the model on every falling edge. Extra literal
// expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = ALU_WIDTH;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        in_valid = 1'b0;
  logic        hold     = 1'b0;
  logic        flush    = 1'b0;
  logic [2:0]  in_op    = '0;
  logic [15:0] in_x     = '0;
  logic [15:0] in_y     = '0;

  logic        in_ready;
  logic        enable;
  logic [15:0] x_out;
  logic [15:0] y_out;
  logic [2:0]  op_out;
  logic [2:0]  count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit quiet  = 1'b0;

  always #5 clk = ~clk;

  alu_issue_queue #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_OPCODE (in_op),
    .IN_X      (in_x),
    .IN_Y      (in_y),
    .HOLD      (hold),
    .FLUSH     (flush),
    .Enable    (enable),
    .X         (x_out),
    .Y         (y_out),
    .Opcode    (op_out),
    .COUNT     (count)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .ISSUE_CNT (issue_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  issue_entry_t m_q[$];
  logic         m_en;
  logic [15:0]  m_x, m_y, m_issue;
  logic [2:0]   m_op;

  always @(posedge clk or negedge rst) begin : model
    issue_entry_t e;
    bit do_pop, do_push;
    if (!rst) begin
      m_q.delete();
      m_en    <= 1'b0;
      m_x     <= '0;
      m_y     <= '0;
      m_op    <= '0;
      m_issue <= '0;
    end else begin
      do_pop  = (m_q.size() != 0) && !hold && !flush;
      do_push = in_valid && (m_q.size() < DEPTH) && !flush;
      if (flush) m_q.delete();
      m_en <= do_pop;
      if (do_pop) begin
        e = m_q.pop_front();
        m_x     <= e.x;
        m_y     <= e.y;
        m_op    <= e.opcode;
        m_issue <= m_issue + 16'd1;
      end
      if (do_push) begin
        e.opcode = in_op;
        e.x      = in_x;
        e.y      = in_y;
        m_q.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("enable",   32'(enable),   32'(m_en));
    chk("x",        32'(x_out),    32'(m_x));
    chk("y",        32'(y_out),    32'(m_y));
    chk("opcode",   32'(op_out),   32'(m_op));
    chk("count",    32'(count),    32'(m_q.size()));
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
`ifdef ALU_ISSUE_STATS_EN
    chk("issue_cnt", 32'(issue_cnt), 32'(m_issue));
`endif
    if (enable && !quiet)
      $display("issue: opcode=%0d x=0x%04h y=0x%04h count=%0d", op_out, x_out, y_out, count);
  end

  // ---------------- stimulus ----------------
  task automatic offer(input logic [2:0] op, input logic [15:0] xv, input logic [15:0] yv);
    in_valid = 1'b1;
    in_op    = op;
    in_x     = xv;
    in_y     = yv;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [2:0] t2_op [4] = '{OP_SUB, OP_AND, OP_NOP, OP_ORA};

  initial begin
    #1 rst = 1'b0;
    tick();
    tick();
    chk("rst_enable", 32'(enable),   32'd0);
    chk("rst_count",  32'(count),    32'd0);
    chk("rst_ready",  32'(in_ready), 32'd1);
    chk("rst_x",      32'(x_out),    32'd0);
    chk("rst_opcode", 32'(op_out),   32'd0);
    rst = 1'b1;
    tick();

    // Single issue latency: push at edge k, Enable after edge k+1.
    offer(OP_ADD, 16'h0003, 16'h0004);
    tick();
    in_valid = 1'b0;
    chk("t1_no_bypass", 32'(enable), 32'd0);
    chk("t1_count",     32'(count),  32'd1);
    tick();
    chk("t1_enable", 32'(enable), 32'd1);
    chk("t1_x",      32'(x_out),  32'h0003);
    chk("t1_y",      32'(y_out),  32'h0004);
    chk("t1_opcode", 32'(op_out), 32'd1);
    tick();
    chk("t1_one_cycle", 32'(enable), 32'd0);
    chk("t1_x_hold",    32'(x_out),  32'h0003);

    // Fill under HOLD, refuse a fifth offer, then drain in order.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(t2_op[i], 16'(16 * (i + 1)), 16'(16 * (i + 1) + 1));
      tick();
    end
    chk("t2_full_count", 32'(count),    32'd4);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    offer(OP_XOR, 16'h0050, 16'h0051);
    tick();
    chk("t2_refused", 32'(count), 32'd4);
    in_valid = 1'b0;
    hold     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_enable", 32'(enable), 32'd1);
      chk("t2_opcode", 32'(op_out), 32'(t2_op[i]));
      chk("t2_x",      32'(x_out),  32'(16 * (i + 1)));
    end
    tick();
    chk("t2_drained", 32'(enable), 32'd0);

    // Full with HOLD low and IN_VALID held: refused in pop cycle, then taken.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(OP_SUB, 16'(32'h0510 + i * 16), 16'(32'h0610 + i * 16));
      tick();
    end
    offer(OP_SHL, 16'h0550, 16'h0650);
    hold = 1'b0;
    tick();
    chk("t3_count_pop",  32'(count),  32'd3);
    chk("t3_enable",     32'(enable), 32'd1);
    chk("t3_first_x",    32'(x_out),  32'h0510);
    tick();
    chk("t3_count_both", 32'(count),  32'd3);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t3_empty",  32'(count), 32'd0);
    chk("t3_last_x", 32'(x_out), 32'h0550);

    // FLUSH with 3 entries and a simultaneous push.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(OP_ORA, 16'(32'h0700 + i), 16'(32'h0800 + i));
      tick();
    end
    chk("t4_pre_count", 32'(count), 32'd3);
    hold  = 1'b0;
    flush = 1'b1;
    offer(OP_AND, 16'h0777, 16'h0778);
    tick();
    chk("t4_count",  32'(count),    32'd0);
    chk("t4_enable", 32'(enable),   32'd0);
    chk("t4_ready",  32'(in_ready), 32'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("t4_dropped", 32'(count),  32'd0);
    chk("t4_no_pulse", 32'(enable), 32'd0);
    chk("t4_x_hold",  32'(x_out),  32'h0550);

    // Mixed traffic: pointer wrap, HOLD against a live Enable, one FLUSH.
    for (int i = 0; i < 24; i++) begin
      in_valid = (i % 3 != 2);
      in_op    = 3'(i);
      in_x     = 16'(32'h1000 + i);
      in_y     = 16'(32'h2000 + i * 3);
      hold     = (i % 5 == 3);
      flush    = (i == 17);
      tick();
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    flush    = 1'b0;
    repeat (6) tick();
    chk("t5_drained", 32'(count), 32'd0);

    // Asynchronous reset between edges while issuing.
    offer(OP_XOR, 16'h0A01, 16'h0B01);
    tick();
    offer(OP_XOR, 16'h0A02, 16'h0B02);
    tick();
    offer(OP_XOR, 16'h0A03, 16'h0B03);
    @(posedge clk);
    #1;
    chk("t6_pre_enable", 32'(enable), 32'd1);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("t6_enable", 32'(enable), 32'd0);
    chk("t6_x",      32'(x_out),  32'd0);
    chk("t6_y",      32'(y_out),  32'd0);
    chk("t6_count",  32'(count),  32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_enable", 32'(enable), 32'd0);
    end

`ifdef ALU_ISSUE_STATS_EN
    // 65537 issues wrap the 16-bit counter to 1.
    quiet    = 1'b1;
    in_valid = 1'b1;
    in_op    = OP_ADD;
    repeat (65537) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("stats_wrap", 32'(issue_cnt), 32'd1);
    quiet = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
